// File: rtl/vram_oam_responder.sv
// ============================================================================
// Module  : vram_oam_responder
// Brief   : VRAM/OAM block RAMs serving PPU fetch channels and a CPU port
//           with DMG mode-based lockout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_oam_ppu_chan #(
    parameter logic [15:0] BASE         = 16'h8000,
    parameter int          DEPTH        = 8192,
    parameter int          IW           = 13,
    parameter int          READ_LATENCY = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [15:0]   addr_i,
    input  logic          addr_valid_i,
    input  logic [7:0]    rd_data_i,
    output logic          port_rd_o,
    output logic [IW-1:0] idx_o,
    output logic [7:0]    data_o,
    output logic          data_valid_o
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic        oor_q;
    logic        served_q;
    logic [15:0] last_q;
    logic [7:0]  data_q;
    logic [15:0] off;
    logic        in_range;
    logic        launch;

    assign off       = addr_i - BASE;
    assign in_range  = off < 16'(DEPTH);
    // A level-held request is suppressed once its address has been served.
    assign launch    = (state_q == S_IDLE) && addr_valid_i && !(served_q && (addr_i == last_q));
    assign port_rd_o = launch && in_range;
    assign idx_o     = off[IW-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            oor_q        <= 1'b0;
            served_q     <= 1'b0;
            last_q       <= 16'h0000;
            data_q       <= 8'h00;
            data_o       <= 8'h00;
            data_valid_o <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            if (!addr_valid_i) begin
                served_q <= 1'b0;
            end else if (launch) begin
                served_q <= 1'b1;
                last_q   <= addr_i;
            end
            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        state_q <= S_WAIT;
                        cnt_q   <= 3'd0;
                        oor_q   <= !in_range;
                    end
                end
                S_WAIT: begin
                    // Shared BRAM output register holds our word only on the first wait cycle.
                    if (cnt_q == 3'd0) begin
                        data_q <= oor_q ? 8'hFF : rd_data_i;
                    end
                    if (cnt_q == 3'(READ_LATENCY - 1)) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_RESP: begin
                    data_o       <= data_q;
                    data_valid_o <= 1'b1;
                    state_q      <= S_HOLD;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

module vram_oam_responder #(
    parameter int READ_LATENCY = 2,
    parameter int VRAM_DEPTH   = 8192,
    parameter int OAM_DEPTH    = 160
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        lcd_on_in,
    input  logic [1:0]  ppu_mode_in,
    input  logic [15:0] ppu_addr_in,
    input  logic        ppu_addr_valid_in,
    output logic [7:0]  ppu_data_out,
    output logic        ppu_data_valid_out,
    input  logic [15:0] oam_addr_in,
    input  logic        oam_addr_valid_in,
    output logic [7:0]  oam_data_out,
    output logic        oam_data_valid_out,
    input  logic [15:0] cpu_addr_in,
    input  logic        cpu_re_in,
    input  logic        cpu_we_in,
    input  logic [7:0]  cpu_wdata_in,
    output logic [7:0]  cpu_rdata_out,
    output logic        cpu_ack_out
);
    localparam int          VIW       = $clog2(VRAM_DEPTH);
    localparam int          OIW       = $clog2(OAM_DEPTH);
    localparam logic [15:0] VRAM_BASE = 16'h8000;
    localparam logic [15:0] OAM_BASE  = 16'hFE00;

    typedef enum logic [1:0] {C_IDLE, C_PEND, C_WAIT} cpu_state_t;

    logic [7:0]     vram_mem [VRAM_DEPTH];
    logic [7:0]     oam_mem  [OAM_DEPTH];
    logic [7:0]     vram_rd_q;
    logic [7:0]     oam_rd_q;

    logic           vppu_rd;
    logic [VIW-1:0] vppu_idx;
    logic           oppu_rd;
    logic [OIW-1:0] oppu_idx;

    cpu_state_t     cpu_state_q;
    logic [15:0]    pend_addr_q;
    logic           pend_we_q;
    logic [7:0]     pend_wdata_q;
    logic [2:0]     cpu_cnt_q;
    logic           cpu_first_q;
    logic [1:0]     cpu_rsel_q;
    logic [7:0]     cpu_hold_q;

    logic           req_act;
    logic [15:0]    req_addr;
    logic           req_we;
    logic [7:0]     req_wdata;
    logic [15:0]    cpu_voff;
    logic [15:0]    cpu_ooff;
    logic           vram_blk;
    logic           oam_blk;
    logic           v_acc;
    logic           o_acc;
    logic           stall;
    logic           issue;
    logic           cpu_v_re;
    logic           cpu_v_we;
    logic           cpu_o_re;
    logic           cpu_o_we;
    logic           vram_re;
    logic [VIW-1:0] vram_idx;
    logic           oam_re;
    logic [OIW-1:0] oam_idx;

    vram_oam_ppu_chan #(
        .BASE(VRAM_BASE), .DEPTH(VRAM_DEPTH), .IW(VIW), .READ_LATENCY(READ_LATENCY)
    ) u_vram_chan (
        .clk_i(clk_in), .rst_i(rst_in),
        .addr_i(ppu_addr_in), .addr_valid_i(ppu_addr_valid_in),
        .rd_data_i(vram_rd_q), .port_rd_o(vppu_rd), .idx_o(vppu_idx),
        .data_o(ppu_data_out), .data_valid_o(ppu_data_valid_out)
    );

    vram_oam_ppu_chan #(
        .BASE(OAM_BASE), .DEPTH(OAM_DEPTH), .IW(OIW), .READ_LATENCY(READ_LATENCY)
    ) u_oam_chan (
        .clk_i(clk_in), .rst_i(rst_in),
        .addr_i(oam_addr_in), .addr_valid_i(oam_addr_valid_in),
        .rd_data_i(oam_rd_q), .port_rd_o(oppu_rd), .idx_o(oppu_idx),
        .data_o(oam_data_out), .data_valid_o(oam_data_valid_out)
    );

    // A fresh strobe is served straight from the pins; a stalled one from the pending register.
    assign req_act   = ((cpu_state_q == C_IDLE) && (cpu_re_in || cpu_we_in)) || (cpu_state_q == C_PEND);
    assign req_addr  = (cpu_state_q == C_PEND) ? pend_addr_q  : cpu_addr_in;
    assign req_we    = (cpu_state_q == C_PEND) ? pend_we_q    : cpu_we_in;
    assign req_wdata = (cpu_state_q == C_PEND) ? pend_wdata_q : cpu_wdata_in;

    assign cpu_voff  = req_addr - VRAM_BASE;
    assign cpu_ooff  = req_addr - OAM_BASE;
    assign vram_blk  = lcd_on_in && (ppu_mode_in == 2'd3);
    assign oam_blk   = lcd_on_in && ppu_mode_in[1];
    assign v_acc     = req_act && (cpu_voff < 16'(VRAM_DEPTH)) && !vram_blk;
    assign o_acc     = req_act && (cpu_ooff < 16'(OAM_DEPTH)) && !oam_blk;
    assign stall     = (v_acc && vppu_rd) || (o_acc && oppu_rd);
    assign issue     = req_act && !stall;
    assign cpu_v_we  = issue && v_acc && req_we;
    assign cpu_v_re  = issue && v_acc && !req_we;
    assign cpu_o_we  = issue && o_acc && req_we;
    assign cpu_o_re  = issue && o_acc && !req_we;

    assign vram_re   = vppu_rd || cpu_v_re;
    assign vram_idx  = vppu_rd ? vppu_idx : cpu_voff[VIW-1:0];
    assign oam_re    = oppu_rd || cpu_o_re;
    assign oam_idx   = oppu_rd ? oppu_idx : cpu_ooff[OIW-1:0];

    always_ff @(posedge clk_in) begin
        if (cpu_v_we) begin
            vram_mem[vram_idx] <= req_wdata;
        end
        if (vram_re) begin
            vram_rd_q <= vram_mem[vram_idx];
        end
    end

    always_ff @(posedge clk_in) begin
        if (cpu_o_we) begin
            oam_mem[oam_idx] <= req_wdata;
        end
        if (oam_re) begin
            oam_rd_q <= oam_mem[oam_idx];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cpu_state_q   <= C_IDLE;
            pend_addr_q   <= 16'h0000;
            pend_we_q     <= 1'b0;
            pend_wdata_q  <= 8'h00;
            cpu_cnt_q     <= 3'd0;
            cpu_first_q   <= 1'b0;
            cpu_rsel_q    <= 2'b00;
            cpu_hold_q    <= 8'h00;
            cpu_rdata_out <= 8'h00;
            cpu_ack_out   <= 1'b0;
        end else begin
            cpu_ack_out <= 1'b0;
            case (cpu_state_q)
                C_WAIT: begin
                    cpu_first_q <= 1'b0;
                    if (cpu_first_q && cpu_rsel_q[0]) begin
                        cpu_hold_q <= vram_rd_q;
                    end
                    if (cpu_first_q && cpu_rsel_q[1]) begin
                        cpu_hold_q <= oam_rd_q;
                    end
                    if (cpu_cnt_q == 3'd0) begin
                        cpu_ack_out   <= 1'b1;
                        cpu_rdata_out <= cpu_hold_q;
                        cpu_state_q   <= C_IDLE;
                    end else begin
                        cpu_cnt_q <= cpu_cnt_q - 3'd1;
                    end
                end
                default: begin
                    if (req_act && issue) begin
                        // Writes, blocked and unmapped accesses complete one cycle after issue.
                        cpu_state_q <= C_WAIT;
                        cpu_first_q <= 1'b1;
                        cpu_rsel_q  <= {cpu_o_re, cpu_v_re};
                        cpu_cnt_q   <= (cpu_v_re || cpu_o_re) ? 3'(READ_LATENCY) : 3'd0;
                        cpu_hold_q  <= 8'hFF;
                    end else if (req_act) begin
                        cpu_state_q  <= C_PEND;
                        pend_addr_q  <= req_addr;
                        pend_we_q    <= req_we;
                        pend_wdata_q <= req_wdata;
                    end
                end
            endcase
        end
    end
endmodule

`default_nettype wire
